// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster timing constants shared by the sync generator and drawing blocks
package vga_timing_pkg;
   localparam int CNT_W = 11;
   typedef logic [CNT_W-1:0] count_t;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam int H_SYNC_START = H_VISIBLE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_VISIBLE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   // Inclusive window test used for the sync pulse decode.
   function automatic logic in_window(input count_t c, input count_t lo, input count_t hi);
      return (c >= lo) && (c <= hi);
   endfunction
endpackage

// File: rtl/pix_tick_div.sv
// rtl/pix_tick_div.sv - modulo-DIV enable generator; registered tick high one clk in DIV
module pix_tick_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick_o
);
   localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] div_q, div_d;
   logic         tick_q;

   always_comb begin
      div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
   end

   // Tick is loaded from the next divider value so it is high while the divider sits at LAST.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= (div_d == LAST);
      end
   end

   assign tick_o = tick_q;
endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters, sync, blank and frame strobe
// Optional pixel-clock divider enabled by VGA_SYNC_DIV_EN.
module vga_sync_gen #(
   parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int   H_FP      = vga_timing_pkg::H_FP,
   parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int   H_BP      = vga_timing_pkg::H_BP,
   parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int   V_FP      = vga_timing_pkg::V_FP,
   parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int   V_BP      = vga_timing_pkg::V_BP,
   parameter logic SYNC_POL  = 1'b0,
   parameter int   CLK_DIV   = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   output logic                             pix_tick,
   output logic [vga_timing_pkg::CNT_W-1:0] hcount,
   output logic [vga_timing_pkg::CNT_W-1:0] vcount,
   output logic                             blank,
   output logic                             hsync,
   output logic                             vsync,
   output logic                             frame_start
);
   import vga_timing_pkg::*;

   localparam count_t H_VIS  = count_t'(H_VISIBLE);
   localparam count_t V_VIS  = count_t'(V_VISIBLE);
   localparam count_t H_LAST = count_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam count_t V_LAST = count_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam count_t H_SS   = count_t'(H_VISIBLE + H_FP);
   localparam count_t H_SE   = count_t'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam count_t V_SS   = count_t'(V_VISIBLE + V_FP);
   localparam count_t V_SE   = count_t'(V_VISIBLE + V_FP + V_SYNC - 1);

   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("CLK_DIV must be at least 1");
   end

   logic   tick;
   count_t hcount_q, hcount_d;
   count_t vcount_q, vcount_d;
   logic   blank_q, blank_d;
   logic   hsync_q, hsync_d;
   logic   vsync_q, vsync_d;

`ifdef VGA_SYNC_DIV_EN
   pix_tick_div #(
      .DIV(CLK_DIV)
   ) u_pix_tick_div (
      .clk    (clk),
      .reset  (reset),
      .tick_o (tick)
   );
`else
   assign tick = 1'b1;
`endif

   // Decodes are taken from the next-state counters so they land with the counters they describe.
   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (tick) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + count_t'(1);
         end else begin
            hcount_d = hcount_q + count_t'(1);
         end
      end
      blank_d = (hcount_d >= H_VIS) || (vcount_d >= V_VIS);
      hsync_d = in_window(hcount_d, H_SS, H_SE) ? SYNC_POL : ~SYNC_POL;
      vsync_d = in_window(vcount_d, V_SS, V_SE) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcount_q <= '0;
         vcount_q <= '0;
         blank_q  <= 1'b0;
         hsync_q  <= ~SYNC_POL;
         vsync_q  <= ~SYNC_POL;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         blank_q  <= blank_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
      end
   end

   assign pix_tick    = tick;
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign blank       = blank_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = tick && (hcount_q == '0) && (vcount_q == '0);
endmodule
